div16_8_seq: RTL and testbench

- Sequential radix-2 restoring unsigned divider; the inverse operation of the team's 8x8 multipliers.
- Divides a 16-bit dividend by an 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder.
- Serves as the reconstruction/check path for multiplier products: feed a product and one operand, recover the other operand.
- Valid/ready handshake on both input and output sides; one quotient bit resolved per clock.

---
 rtl/div16_8_seq_if.sv | 26 ++
 rtl/div16_8_seq.sv | 106 ++++++++++
 tb/tb_div16_8_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div16_8_seq_if.sv
// Handshake bundle for the sequential 16/8 divider: operand request on one side,
// quotient/remainder response on the other.
interface div16_8_seq_if #(
    parameter int N_DEND = 16,
    parameter int N_DSOR = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N_DEND-1:0] dividend;
    logic [N_DSOR-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [N_DEND-1:0] quotient;
    logic [N_DSOR-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_8_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock. Recovers one
// multiplier operand from a product and the other operand.
module div16_8_seq #(
    parameter int N_DEND = 16,
    parameter int N_DSOR = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    div16_8_seq_if.slave bus
);
    localparam int CNT_W = $clog2(N_DEND);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q;
    logic              inReady_q;
    logic              outValid_q;
    logic [N_DEND-1:0] quot_q;
    logic [N_DSOR-1:0] rem_q;
    logic              dbz_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_DEND-1:0] dendSh_q;
    logic [N_DSOR-1:0] dsor_q;
    logic [N_DSOR-1:0] partRem_q;

    logic [N_DSOR:0]   shifted;
    logic [N_DSOR:0]   trial;
    logic              qBit;
    logic [N_DSOR-1:0] partRem_d;
    logic [N_DEND-1:0] dendSh_d;

    // The partial remainder is always below the divisor, so the shifted value is
    // under twice the divisor and the top bit of the 9-bit trial is a true sign.
    always_comb begin
        shifted   = {partRem_q, dendSh_q[N_DEND-1]};
        trial     = shifted - {1'b0, dsor_q};
        qBit      = ~trial[N_DSOR];
        partRem_d = qBit ? trial[N_DSOR-1:0] : shifted[N_DSOR-1:0];
        dendSh_d  = {dendSh_q[N_DEND-2:0], qBit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            cnt_q      <= '0;
            dendSh_q   <= '0;
            dsor_q     <= '0;
            partRem_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && inReady_q) begin
                        inReady_q <= 1'b0;
                        if (bus.divisor != '0) begin
                            dendSh_q  <= bus.dividend;
                            dsor_q    <= bus.divisor;
                            partRem_q <= '0;
                            cnt_q     <= CNT_W'(N_DEND - 1);
                            state_q   <= CALC;
                        end else begin
                            quot_q     <= '1;
                            rem_q      <= bus.dividend[N_DSOR-1:0];
                            dbz_q      <= 1'b1;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                CALC: begin
                    dendSh_q  <= dendSh_d;
                    partRem_q <= partRem_d;
                    if (cnt_q == '0) begin
                        quot_q     <= dendSh_d;
                        rem_q      <= partRem_d;
                        dbz_q      <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = inReady_q;
    assign bus.out_valid   = outValid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div16_8_seq.sv
// Bench for div16_8_seq: directed vectors with literal results plus an arithmetic
// reference model that watches every cycle.
module tb_div16_8_seq;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   lastAcceptCyc;
    bit   randStall;
    bit   forcedReady;

    div16_8_seq_if ifc ();

    div16_8_seq dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          acceptCyc;
        int          lat;
    } expect_t;

    expect_t     pending[$];
    logic [15:0] lastQ;
    logic [7:0]  lastR;
    logic        lastDbz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready = randStall ? 1'($urandom_range(0, 1)) : forcedReady;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency is counted in edges from the accept edge to the edge that raises
    // out_valid: 16 for a real division, 0 when the divisor is zero.
    initial begin
        expect_t e;
        int      el;
        lastQ   = '0;
        lastR   = '0;
        lastDbz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending.delete();
                lastQ   = '0;
                lastR   = '0;
                lastDbz = 1'b0;
            end else begin
                if (pending.size() == 0) begin
                    check("model.idle.in_ready", ifc.in_ready, 1);
                    check("model.idle.out_valid", ifc.out_valid, 0);
                    check("model.idle.quotient", ifc.quotient, lastQ);
                    check("model.idle.remainder", ifc.remainder, lastR);
                    check("model.idle.div_by_zero", ifc.div_by_zero, lastDbz);
                end else begin
                    e  = pending[0];
                    el = cyc - e.acceptCyc;
                    check("model.busy.in_ready", ifc.in_ready, 0);
                    check("model.busy.out_valid", ifc.out_valid, 32'(el >= e.lat));
                    if (ifc.out_valid) begin
                        check("model.quotient", ifc.quotient, e.q);
                        check("model.remainder", ifc.remainder, e.r);
                        check("model.div_by_zero", ifc.div_by_zero, e.dbz);
                        if (e.b != 0) begin
                            check("model.identity", 32'(ifc.quotient) * 32'(e.b) + 32'(ifc.remainder), 32'(e.a));
                            check("model.remLtDsor", 32'(ifc.remainder < e.b), 1);
                        end
                        if (ifc.out_ready) begin
                            lastQ   = e.q;
                            lastR   = e.r;
                            lastDbz = e.dbz;
                            void'(pending.pop_front());
                        end
                    end
                end
                if (ifc.in_valid && ifc.in_ready) begin
                    e.a         = ifc.dividend;
                    e.b         = ifc.divisor;
                    e.acceptCyc = cyc + 1;
                    if (e.b == 0) begin
                        e.q   = 16'hFFFF;
                        e.r   = e.a[7:0];
                        e.dbz = 1'b1;
                        e.lat = 0;
                    end else begin
                        e.q   = e.a / {8'h00, e.b};
                        e.r   = 8'(e.a % {8'h00, e.b});
                        e.dbz = 1'b0;
                        e.lat = 16;
                    end
                    pending.push_back(e);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        ifc.dividend = a;
        ifc.divisor  = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept.timeout", 0, 1);
        lastAcceptCyc = cyc + 1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.dividend = 16'($urandom);
        ifc.divisor  = 8'($urandom);
    endtask

    task automatic waitValid(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (ifc.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, ".timeout"}, 0, 1);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] q, input logic [7:0] r,
                               input logic dbz, input int lat);
        waitValid(name);
        check({name, ".quotient"}, ifc.quotient, q);
        check({name, ".remainder"}, ifc.remainder, r);
        check({name, ".div_by_zero"}, ifc.div_by_zero, dbz);
        check({name, ".latency"}, cyc - lastAcceptCyc, lat);
    endtask

    task automatic finishResult(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (ifc.out_valid && ifc.out_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check({name, ".handshakeTimeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        lastAcceptCyc = 0;
        randStall     = 1'b0;
        forcedReady   = 1'b1;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.dividend  = '0;
        ifc.divisor   = '0;

        repeat (3) @(negedge clk);
        check("reset.in_ready", ifc.in_ready, 1);
        check("reset.out_valid", ifc.out_valid, 0);
        check("reset.quotient", ifc.quotient, 0);
        check("reset.remainder", ifc.remainder, 0);
        check("reset.div_by_zero", ifc.div_by_zero, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 65535 = 257 * 255
        applyStimulus(16'hFFFF, 8'hFF);
        checkOutput("maxByMax", 16'h0101, 8'h00, 1'b0, 16);
        @(negedge clk);
        check("maxByMax.pulseDrop", ifc.out_valid, 0);
        check("maxByMax.readyBack", ifc.in_ready, 1);

        // 1000 = 142 * 7 + 6
        applyStimulus(16'h03E8, 8'h07);
        checkOutput("thousandBy7", 16'h008E, 8'h06, 1'b0, 16);
        finishResult("thousandBy7");
        applyStimulus(16'h00C8, 8'hC8);
        checkOutput("equal", 16'h0001, 8'h00, 1'b0, 16);
        finishResult("equal");

        applyStimulus(16'h0005, 8'h00);
        checkOutput("divZero", 16'hFFFF, 8'h05, 1'b1, 0);
        finishResult("divZero");

        forcedReady = 1'b0;
        applyStimulus(16'h0030, 8'h40);
        checkOutput("small", 16'h0000, 8'h30, 1'b0, 16);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            ifc.in_valid = 1'b1;
            ifc.dividend = 16'h0100;
            ifc.divisor  = 8'h02;
            @(negedge clk);
            check("stall.in_ready", ifc.in_ready, 0);
            check("stall.out_valid", ifc.out_valid, 1);
            check("stall.quotient", ifc.quotient, 16'h0000);
            check("stall.remainder", ifc.remainder, 8'h30);
        end
        ifc.in_valid = 1'b0;
        forcedReady  = 1'b1;
        finishResult("small");
        applyStimulus(16'h0100, 8'h02);
        checkOutput("afterStall", 16'h0080, 8'h00, 1'b0, 16);
        finishResult("afterStall");

        // 0x1234 = 4660 = 258 * 18 + 16
        applyStimulus(16'h1234, 8'h12);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midReset.out_valid", ifc.out_valid, 0);
        check("midReset.in_ready", ifc.in_ready, 1);
        check("midReset.quotient", ifc.quotient, 0);
        check("midReset.remainder", ifc.remainder, 0);
        check("midReset.div_by_zero", ifc.div_by_zero, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("midReset.noValid", ifc.out_valid, 0);
        end
        applyStimulus(16'h1234, 8'h12);
        checkOutput("afterReset", 16'h0102, 8'h10, 1'b0, 16);
        finishResult("afterReset");

        randStall = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = (i % 5 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(a, b);
            waitValid("sweep");
            finishResult("sweep");
        end
        randStall = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
